la_capture: RTL and testbench
=============================

# la_capture

Parametrised multi-channel logic-analyser capture engine, successor to the fixed single-channel 4-bit probe used in the logic-analyser harness. Samples CHANNELS×WIDTH probe bits every clock into a circular sample RAM. Triggers on a masked level or edge pattern with a programmable pre-trigger depth, then streams the captured window out oldest-first over a valid/ready port. Sits between the probed design and the host readout/UART bridge.

## Interface
- CHANNELS, 2, number of probe channels
- WIDTH, 4, bits per channel; sample width SW = CHANNELS*WIDTH
- DEPTH, 256, samples per capture (power of two, ≥4)
- AW, 8, log2(DEPTH)

- clk  in  1  capture clock, all logic on rising edge
- reset  in  1  synchronous, active-low; one clock, synchronous reset, active-low
- io_in  in  SW  probe sample, channel k at bits [k*WIDTH +: WIDTH]
- io_trig_value  in  SW  trigger compare value
- io_trig_mask  in  SW  1 = bit participates in compare
- io_trig_edge  in  1  0 = level mode, 1 = edge mode (rising into match)
- io_pretrig  in  AW  samples kept before trigger, clamped to DEPTH-1
- io_arm  in  1  one-cycle start request, honoured only in IDLE
- io_abort  in  1  return to IDLE from any state
- io_rd_valid  out  1  readout word valid
- io_rd_ready  in  1  host accepts word
- io_rd_data  out  SW  readout sample
- io_rd_last  out  1  marks final (DEPTH-th) word
- io_state  out  2  0 IDLE, 1 FILL, 2 ARMED, 3 POST/READ (see io_triggered)
- io_triggered  out  1  high from trigger sample until return to IDLE

## Operation
- match = ((io_in ^ io_trig_value) & io_trig_mask) == 0; mask all-zero ⇒ always match.
- IDLE: no writes. io_arm ⇒ wr_ptr=0, fill_cnt=0, prev_match=1, P=min(io_pretrig,DEPTH-1) latched, → FILL (or ARMED directly if P==0).
- FILL: write io_in at wr_ptr, wr_ptr++ (mod DEPTH), fill_cnt++; when fill_cnt reaches P → ARMED. Matches ignored.
- ARMED: write every cycle, wr_ptr wraps. Fire when level mode & match, or edge mode & match & !prev_match. prev_match <= match each ARMED cycle. Firing sample is written; trig_ptr = its address; io_triggered=1; post_cnt = DEPTH-1-P; → POST (or READ if post_cnt==0).
- POST: write every cycle, post_cnt-- ; at 0 → READ. Total stored = P + 1 + (DEPTH-1-P) = DEPTH.
- READ: rd_ptr starts at (trig_ptr - P) mod DEPTH; emits DEPTH words, increment mod DEPTH; io_rd_last on word DEPTH-1. Handshake on valid&ready; after last handshake → IDLE, io_triggered=0.
- io_abort (any state, priority over all) ⇒ IDLE next cycle, rd_valid=0, triggered=0, RAM contents undefined for next read.
- io_arm outside IDLE ignored. io_arm and io_abort same cycle ⇒ abort wins, stay IDLE.
- Trigger config inputs sampled live each cycle; host must hold them stable while armed.

## Timing
- Reset: state IDLE, io_rd_valid=0, io_rd_last=0, io_rd_data=0, io_triggered=0, io_state=0, pointers/counters 0.
- Arm at edge n ⇒ io_in at edge n+1 is sample 0.
- Trigger at edge t: io_state=3, io_triggered=1 visible after edge t.
- Final post-trigger write at edge f ⇒ io_rd_valid rises after edge f+2 (synchronous RAM read latency 1).
- With io_rd_ready held high: one word per cycle, no bubbles; DEPTH words in DEPTH cycles.
- valid&&!ready: io_rd_data, io_rd_last held stable; valid never drops before handshake.
- io_rd_valid low the cycle after the last handshake; io_state=0 same edge.
- Reset asserted mid-capture or mid-read: all outputs to reset values at that edge.

## Test plan
- Level trigger, CHANNELS=2 WIDTH=4 DEPTH=16, P=4, mask 0xFF value 0x0A, io_in counts 0x00,0x01,… from arm → readout 0x06..0x15, first word 0x06, trigger word 0x0A is 5th, rd_last on 0x15.
- Edge mode, mask 0x01 value 0x01, io_in bit0 high at arm for 10 cycles then low 3 then high → fires on first re-rise, not at arm.
- P=0 and P=20 (clamped to 15): trigger word is first resp. 16th (last) readout word.
- Backpressure: rd_ready toggled 1,0,0,1 pattern → 16 words, no duplicates/drops, data stable during stalls.
- Abort in ARMED, then in READ after 5 words → io_state=0, rd_valid=0 next cycle; rearm captures correctly.
- Reset low for one cycle mid-POST → all outputs zero, arm ignored during reset, fresh capture afterwards correct.

Source files
------------

// File: rtl/la_capture.sv
// la_capture: multi-channel logic-analyser capture into a circular RAM with masked level/edge
// trigger, programmable pre-trigger depth and oldest-first valid/ready readout.
module la_capture #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 256,
  parameter int AW       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] io_in,
  input  logic [CHANNELS*WIDTH-1:0] io_trig_value,
  input  logic [CHANNELS*WIDTH-1:0] io_trig_mask,
  input  logic                      io_trig_edge,
  input  logic [AW-1:0]             io_pretrig,
  input  logic                      io_arm,
  input  logic                      io_abort,
  output logic                      io_rd_valid,
  input  logic                      io_rd_ready,
  output logic [CHANNELS*WIDTH-1:0] io_rd_data,
  output logic                      io_rd_last,
  output logic [1:0]                io_state,
  output logic                      io_triggered
);
  localparam int SW = CHANNELS * WIDTH;
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READ} state_t;
  state_t state, nxt;
  logic [SW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, fill_cnt, post_cnt, p_lat, p_in;
  logic [PW:0] fcnt;
  logic prev_match, primed, match, fire, we, load;
  always_comb begin
    match = ((io_in ^ io_trig_value) & io_trig_mask) == '0;
    fire = state == ARMED && match && (!io_trig_edge || !prev_match);
    we = state == FILL || state == ARMED || state == POST;
    load = state == READ && primed && fcnt != (PW+1)'(DEPTH) && (!io_rd_valid || io_rd_ready);
    p_in = ({1'b0, io_pretrig} > (AW+1)'(DEPTH - 1)) ? PW'(DEPTH - 1) : io_pretrig[PW-1:0];
    io_state = state == IDLE ? 2'd0 : state == FILL ? 2'd1 : state == ARMED ? 2'd2 : 2'd3;
    io_triggered = state == POST || state == READ;
  end
  always_comb begin
    nxt = state;
    if (state == IDLE && io_arm) nxt = p_in == '0 ? ARMED : FILL;
    if (state == FILL && fill_cnt + PW'(1) == p_lat) nxt = ARMED;
    if (fire) nxt = p_lat == PW'(DEPTH - 1) ? READ : POST;
    if (state == POST && post_cnt == PW'(1)) nxt = READ;
    if (state == READ && io_rd_valid && io_rd_ready && io_rd_last) nxt = IDLE;
    if (io_abort) nxt = IDLE;
  end
  always_ff @(posedge clk) state <= !reset ? IDLE : nxt;
  always_ff @(posedge clk) if (we) mem[wr_ptr] <= io_in;
  // the first READ cycle only primes the RAM address, so data follows the final write by two edges
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
      p_lat <= '0;
      fcnt <= '0;
      prev_match <= 1'b0;
      primed <= 1'b0;
      io_rd_valid <= 1'b0;
      io_rd_last <= 1'b0;
      io_rd_data <= '0;
    end else begin
      primed <= state == READ && !io_abort;
      if (we) wr_ptr <= wr_ptr + PW'(1);
      if (state == FILL) fill_cnt <= fill_cnt + PW'(1);
      if (state == ARMED) prev_match <= match;
      if (state == POST) post_cnt <= post_cnt - PW'(1);
      if (fire) begin
        post_cnt <= PW'(DEPTH - 1) - p_lat;
        rd_ptr <= wr_ptr - p_lat;
      end
      if (state == IDLE && io_arm) begin
        wr_ptr <= '0;
        fill_cnt <= '0;
        prev_match <= 1'b1;
        p_lat <= p_in;
        fcnt <= '0;
      end
      if (load) begin
        io_rd_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
        fcnt <= fcnt + (PW+1)'(1);
        io_rd_last <= fcnt == (PW+1)'(DEPTH - 1);
        io_rd_valid <= 1'b1;
      end else if (io_rd_valid && io_rd_ready) begin
        io_rd_valid <= 1'b0;
        io_rd_last <= 1'b0;
      end
      if (io_abort) begin
        io_rd_valid <= 1'b0;
        io_rd_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_la_capture.sv
// tb_la_capture: table-driven, corner-sequence and randomized checks of la_capture (DEPTH=16)
// against a model that locates the trigger in the stimulus array and slices the expected window.
module tb_la_capture;
  localparam int D = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic [7:0] io_in = '0, io_trig_value = '0, io_trig_mask = '0, io_rd_data;
  logic [4:0] io_pretrig = '0;
  logic io_trig_edge = 1'b0, io_arm = 1'b0, io_abort = 1'b0, io_rd_ready = 1'b0;
  logic io_rd_valid, io_rd_last, io_triggered;
  logic [1:0] io_state;
  int checks = 0, errors = 0;
  logic [7:0] samp [256];
  logic [7:0] rd_words [D];
  typedef struct {
    bit e; logic [7:0] mk; logic [7:0] vl; logic [4:0] pr; int pat; int rp;
    logic [7:0] first; int tpos; logic [7:0] tword;
  } vec_t;
  vec_t v [5];

  la_capture #(.CHANNELS(2), .WIDTH(4), .DEPTH(D), .AW(5)) dut (
    .clk(clk), .reset(reset), .io_in(io_in), .io_trig_value(io_trig_value),
    .io_trig_mask(io_trig_mask), .io_trig_edge(io_trig_edge), .io_pretrig(io_pretrig),
    .io_arm(io_arm), .io_abort(io_abort), .io_rd_valid(io_rd_valid), .io_rd_ready(io_rd_ready),
    .io_rd_data(io_rd_data), .io_rd_last(io_rd_last), .io_state(io_state),
    .io_triggered(io_triggered)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] s(input int k);
    return samp[k[7:0]];
  endfunction

  function automatic bit mt(input int k, input logic [7:0] mk, input logic [7:0] vl);
    return ((s(k) ^ vl) & mk) == 8'h00;
  endfunction

  // trigger sample index counted from the first sample after arm; -1 if none in range
  function automatic int find_trig(input bit e, input logic [7:0] mk, input logic [7:0] vl, input int p);
    for (int k = p; k < 150; k++)
      if (mt(k, mk, vl) && (!e || (k > p && !mt(k - 1, mk, vl)))) return k;
    return -1;
  endfunction

  task automatic fill(input int pat);
    for (int k = 0; k < 256; k++)
      samp[k] = pat == 0 ? k[7:0] : pat == 1 ? {k[6:0], (k < 10 || k >= 13)} : 8'($urandom);
  endtask

  // kind 0: full capture; 1: abort after `at` readout words; 2: reset at loop cycle `at`
  task automatic run_cap(input bit e, input logic [7:0] mk, input logic [7:0] vl,
                         input logic [4:0] pr, input int rp, input int kind, input int at);
    int p, t, fi, cyc, n, h0, h1;
    bit stall, r, hl;
    logic [7:0] hd;
    logic [3:0] rpat;
    p = (pr > 5'd15) ? 15 : int'(pr);
    t = find_trig(e, mk, vl, p);
    if (t < 0) begin
      chk("trig_found", 0, 1);
      return;
    end
    fi = t + D - 1 - p;
    rpat = 4'b1001;
    @(negedge clk);
    io_trig_edge = e; io_trig_mask = mk; io_trig_value = vl; io_pretrig = pr;
    io_arm = 1'b1; io_rd_ready = 1'b0;
    @(negedge clk);
    io_arm = 1'b0;
    n = 0; cyc = 0; stall = 1'b0; h0 = 0; h1 = 0; hd = '0; hl = 1'b0;
    while (n < D && cyc < 400) begin
      if (kind == 1 && n == at) begin
        io_abort = 1'b1; io_rd_ready = 1'b0;
        @(negedge clk);
        io_abort = 1'b0;
        chk("abort_read", int'({io_state, io_rd_valid, io_triggered}), 0);
        return;
      end
      if (kind == 2 && cyc == at) begin
        reset = 1'b0; io_arm = 1'b1;
        @(negedge clk);
        chk("reset_outs", int'({io_rd_data, io_state, io_rd_valid, io_rd_last, io_triggered}), 0);
        reset = 1'b1; io_arm = 1'b0;
        @(negedge clk);
        chk("arm_in_reset", int'(io_state), 0);
        return;
      end
      if (cyc == t) chk("pre_fire", int'({io_state, io_triggered}), int'({2'd2, 1'b0}));
      if (cyc == t + 1) chk("post_fire", int'({io_state, io_triggered}), int'({2'd3, 1'b1}));
      if (cyc == fi + 2) chk("valid_early", int'(io_rd_valid), 0);
      if (cyc == fi + 3) chk("valid_rise", int'(io_rd_valid), 1);
      if (stall) chk("stall_hold", int'({io_rd_valid, io_rd_last, io_rd_data}), int'({1'b1, hl, hd}));
      r = rp == 0 ? 1'b1 : rp == 1 ? rpat[2'(cyc)] : 1'($urandom_range(1));
      io_rd_ready = r;
      stall = io_rd_valid && !r; hd = io_rd_data; hl = io_rd_last;
      if (io_rd_valid && r) begin
        rd_words[4'(n)] = io_rd_data;
        chk("word", int'({io_rd_last, io_rd_data}), int'({n == D - 1, s(t - p + n)}));
        if (n == 0) h0 = cyc;
        h1 = cyc;
        n++;
      end
      io_in = cyc < 256 ? s(cyc) : 8'h00;
      cyc++;
      @(negedge clk);
    end
    io_rd_ready = 1'b0;
    if (n < D) chk("timeout", n, D);
    if (rp == 0 && n == D) chk("no_bubble", h1 - h0, D - 1);
    chk("done", int'({io_state, io_rd_valid, io_triggered}), 0);
  endtask

  initial begin
    v[0] = '{1'b0, 8'hFF, 8'h0A, 5'd4,  0, 0, 8'h06, 5,  8'h0A};
    v[1] = '{1'b0, 8'hFF, 8'h05, 5'd0,  0, 0, 8'h05, 1,  8'h05};
    v[2] = '{1'b0, 8'hFF, 8'h14, 5'd20, 0, 0, 8'h05, 16, 8'h14};
    v[3] = '{1'b0, 8'hFF, 8'h0A, 5'd4,  0, 1, 8'h06, 5,  8'h0A};
    v[4] = '{1'b1, 8'h01, 8'h01, 5'd4,  1, 0, 8'h13, 5,  8'h1B};
    repeat (3) @(negedge clk);
    chk("reset_state", int'({io_rd_data, io_state, io_rd_valid, io_rd_last, io_triggered}), 0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fill(v[i].pat);
      run_cap(v[i].e, v[i].mk, v[i].vl, v[i].pr, v[i].rp, 0, 0);
      chk("first_word", int'(rd_words[0]), int'(v[i].first));
      chk("trig_word", int'(rd_words[4'(v[i].tpos - 1)]), int'(v[i].tword));
    end
    fill(0);
    @(negedge clk);
    io_in = 8'h00; io_trig_edge = 1'b0; io_trig_mask = 8'hFF; io_trig_value = 8'hFF;
    io_pretrig = 5'd4; io_arm = 1'b1;
    @(negedge clk);
    io_arm = 1'b0;
    repeat (8) @(negedge clk);
    chk("armed", int'(io_state), 2);
    io_arm = 1'b1;
    @(negedge clk);
    io_arm = 1'b0;
    chk("arm_ignored", int'(io_state), 2);
    io_abort = 1'b1;
    @(negedge clk);
    io_abort = 1'b0;
    chk("abort_armed", int'({io_state, io_rd_valid, io_triggered}), 0);
    io_arm = 1'b1; io_abort = 1'b1;
    @(negedge clk);
    io_arm = 1'b0; io_abort = 1'b0;
    chk("arm_abort", int'(io_state), 0);
    run_cap(1'b0, 8'hFF, 8'h0A, 5'd4, 0, 0, 0);
    chk("rearm_first", int'(rd_words[0]), 8'h06);
    run_cap(1'b0, 8'hFF, 8'h0A, 5'd4, 0, 1, 5);
    run_cap(1'b0, 8'hFF, 8'h0A, 5'd4, 1, 0, 0);
    chk("after_abort_first", int'(rd_words[0]), 8'h06);
    run_cap(1'b0, 8'hFF, 8'h0A, 5'd4, 0, 2, 13);
    run_cap(1'b0, 8'hFF, 8'h0A, 5'd4, 0, 0, 0);
    chk("after_reset_first", int'(rd_words[0]), 8'h06);
    for (int i = 0; i < 6; i++) begin
      bit e;
      logic [7:0] mk, vl;
      logic [4:0] pr;
      int p, t, tries;
      tries = 0;
      do begin
        fill(2);
        e = 1'($urandom_range(1));
        mk = 8'(1 << $urandom_range(7)) | 8'(1 << $urandom_range(7));
        vl = 8'($urandom);
        pr = 5'($urandom_range(20));
        p = (pr > 5'd15) ? 15 : int'(pr);
        t = find_trig(e, mk, vl, p);
        tries++;
      end while ((t < 0 || t + D - p > 140) && tries < 50);
      run_cap(e, mk, vl, pr, 2, 0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
